// File: rtl/alu_request_arbiter_pkg.sv
// alu_ctrl_pkg: ALU select codes, legal-opcode check and arbiter state encoding
package alu_ctrl_pkg;
  localparam logic [3:0] SEL_ADD = 4'b0100;
  localparam logic [3:0] SEL_SUBTRACT = 4'b0101;
  localparam logic [3:0] SEL_INVERT_A = 4'b1000;
  localparam logic [3:0] SEL_OR = 4'b1001;
  localparam logic [3:0] SEL_AND = 4'b1010;
  localparam logic [3:0] SEL_XOR = 4'b1011;
  localparam logic [3:0] SEL_SHIFT_LEFT = 4'b1100;
  localparam logic [3:0] SEL_SHIFT_RIGHT = 4'b1101;
  localparam logic [3:0] SEL_SHIFT_RIGHT_ARITH = 4'b1110;
  localparam logic [3:0] SEL_PASS_A = 4'b1111;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESPOND = 2'd2} state_t;
  function automatic logic is_legal(input logic [3:0] s);
    return s == SEL_ADD || s == SEL_SUBTRACT || s[3];
  endfunction
endpackage

// File: rtl/alu_request_arbiter_if.sv
// alu_request_arbiter_if: request, ALU and response signals shared by requesters and the arbiter
interface alu_request_arbiter_if #(
  parameter int DataLength = 4,
  parameter int NumRequesters = 4,
  parameter int IdWidth = 2
);
  logic [NumRequesters-1:0] req_valid;
  logic [NumRequesters-1:0] req_ready;
  logic [4*NumRequesters-1:0] req_select;
  logic [DataLength*NumRequesters-1:0] req_a;
  logic [DataLength*NumRequesters-1:0] req_b;
  logic [NumRequesters-1:0] req_carry_in;
  logic [3:0] alu_select;
  logic [DataLength-1:0] alu_a;
  logic [DataLength-1:0] alu_b;
  logic alu_carry_in;
  logic [DataLength-1:0] alu_result;
  logic alu_carry_out;
  logic rsp_valid;
  logic rsp_ready;
  logic [IdWidth-1:0] rsp_id;
  logic [DataLength-1:0] rsp_result;
  logic rsp_carry_out;
  logic rsp_illegal;
  modport slave(
    input req_valid, req_select, req_a, req_b, req_carry_in, alu_result, alu_carry_out, rsp_ready,
    output req_ready, alu_select, alu_a, alu_b, alu_carry_in, rsp_valid, rsp_id, rsp_result,
    rsp_carry_out, rsp_illegal
  );
  modport master(
    output req_valid, req_select, req_a, req_b, req_carry_in, alu_result, alu_carry_out, rsp_ready,
    input req_ready, alu_select, alu_a, alu_b, alu_carry_in, rsp_valid, rsp_id, rsp_result,
    rsp_carry_out, rsp_illegal
  );
endinterface

// File: rtl/alu_request_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin search for the first request at or after ptr
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         any
);
  logic [W-1:0] j;
  // Scan offsets from farthest to nearest so the nearest valid index at or after ptr wins
  always_comb begin
    idx = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = W'((int'(ptr) + k) % N);
      idx = req[j] ? j : idx;
    end
    any = |req;
    grant = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/alu_request_arbiter.sv
// alu_request_arbiter: round-robin sharing of one external ALU between several requesters
module alu_request_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int DataLength = 4,
  parameter int NumRequesters = 4,
  parameter int IdWidth = 2
) (
  input logic clk,
  input logic rst,
  alu_request_arbiter_if.slave bus
);
  state_t state, state_next;
  logic [IdWidth-1:0] ptr, id, win;
  logic [NumRequesters-1:0] grant;
  logic any;
  logic [3:0] sel;
  logic [DataLength-1:0] op_a, op_b, result;
  logic op_c, carry, illegal;
  rr_arbiter #(.N(NumRequesters), .W(IdWidth)) u_arb (
    .req(bus.req_valid),
    .ptr(ptr),
    .grant(grant),
    .idx(win),
    .any(any)
  );
  assign bus.req_ready = (state == IDLE && !rst) ? grant : '0;
  assign bus.alu_select = sel;
  assign bus.alu_a = op_a;
  assign bus.alu_b = op_b;
  assign bus.alu_carry_in = op_c;
  assign bus.rsp_valid = state == RESPOND;
  assign bus.rsp_id = id;
  assign bus.rsp_result = result;
  assign bus.rsp_carry_out = carry;
  assign bus.rsp_illegal = illegal;
  // Grant moves to ISSUE, ISSUE lasts one cycle, RESPOND waits for the consumer
  always_comb begin
    state_next = state == IDLE ? (any ? ISSUE : IDLE) : state == ISSUE ? RESPOND : (bus.rsp_ready ? IDLE : RESPOND);
  end
  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_next;
  end
  // Latch operands on grant, capture the ALU in ISSUE, advance the pointer on the response handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
      id <= '0;
      sel <= '0;
      op_a <= '0;
      op_b <= '0;
      op_c <= 1'b0;
      result <= '0;
      carry <= 1'b0;
      illegal <= 1'b0;
    end else begin
      if (state == IDLE && any) begin
        sel <= bus.req_select[4*win +: 4];
        op_a <= bus.req_a[DataLength*win +: DataLength];
        op_b <= bus.req_b[DataLength*win +: DataLength];
        op_c <= bus.req_carry_in[win];
        id <= win;
      end
      if (state == ISSUE) begin
        result <= bus.alu_result;
        carry <= bus.alu_carry_out;
        illegal <= !is_legal(sel);
      end
      if (state == RESPOND && bus.rsp_ready) ptr <= id == IdWidth'(NumRequesters - 1) ? '0 : id + 1'b1;
    end
  end
endmodule
